// File: rtl/gcd_cpu_pkg.sv
// Shared definitions for the GCD CPU pipeline stages: datapath defaults,
// the hardwired zero register index and the writeback FSM state type.
package gcd_cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

endpackage

// File: rtl/gcd_regfile.sv
// Architectural register file: r0 reads as zero, one write port, two decode
// read ports plus a capture port, all with same-cycle write bypass.
module gcd_regfile
  import gcd_cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int CAP_REG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] cap_data
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] CAP_A  = ADDR_W'(CAP_REG);

  logic [DATA_W-1:0] regs_q [NREGS];

  // A write landing this cycle wins over the stored value for any nonzero index.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    if (addr == ZERO_A)
      return '0;
    else if (wr_en && (wr_addr == addr))
      return wr_data;
    else
      return stored;
  endfunction

  assign rs_data  = read_port(rs_addr, regs_q[rs_addr]);
  assign rt_data  = read_port(rt_addr, regs_q[rt_addr]);
  assign cap_data = read_port(CAP_A, regs_q[CAP_A]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en && (wr_addr != ZERO_A)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/gcd_writeback_stage.sv
// WB stage of the GCD CPU: register file owner, retire counter and the
// RUN -> DRAIN -> HALTED sequencer that snapshots the result register.
module gcd_writeback_stage
  import gcd_cpu_pkg::*;
#(
  parameter int DATA_W       = CPU_DATA_W,
  parameter int ADDR_W       = CPU_ADDR_W,
  parameter int RESULT_REG   = 2,
  parameter int DRAIN_CYCLES = 2,
  parameter int COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MW_valid,
  input  logic [ADDR_W-1:0]  MW_RD,
  input  logic [DATA_W-1:0]  MW_ALUout,
  input  logic               halt_req,
  input  logic [ADDR_W-1:0]  rs_addr,
  input  logic [ADDR_W-1:0]  rt_addr,
  output logic [DATA_W-1:0]  rs_data,
  output logic [DATA_W-1:0]  rt_data,
  output logic [COUNT_W-1:0] retire_count,
  output logic               halted,
  output logic [DATA_W-1:0]  result,
  output wb_state_t          state_dbg
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  wb_state_t            state_q, state_d;
  logic [DRAIN_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [DATA_W-1:0]    cap_data;
  logic                 wr_en;
  logic                 running;

  assign running = (state_q != HALTED);
  assign wr_en   = MW_valid && (MW_RD != ADDR_W'(REG_ZERO)) && running;

  gcd_regfile #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .CAP_REG (RESULT_REG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (MW_RD),
    .wr_data  (MW_ALUout),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .cap_data (cap_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (halt_req) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = HALTED;
          end else begin
            state_d = DRAIN;
            cnt_d   = DRAIN_W'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - DRAIN_W'(1);
        if (cnt_q == DRAIN_W'(1)) state_d = HALTED;
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  // Snapshot uses the bypassed view so a write in the final cycle is included.
  always_comb begin
    result_d = result_q;
    if (running && (state_d == HALTED)) result_d = cap_data;
  end

  always_comb begin
    count_d = count_q;
    if (MW_valid && running && (count_q != '1)) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign retire_count = count_q;
  assign halted       = (state_q == HALTED);
  assign result       = result_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_gcd_writeback_stage.sv
// Bench for gcd_writeback_stage: three instances (default, zero drain,
// 4-bit counter) share one stimulus stream and are scored against a model.
module tb_gcd_writeback_stage;
  import gcd_cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        mw_valid;
  logic [4:0]  mw_rd;
  logic [31:0] mw_aluout;
  logic        halt_req;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;

  logic [31:0] rs_a, rt_a, cnt_a, res_a;
  logic [31:0] rs_b, rt_b, cnt_b, res_b;
  logic [31:0] rs_c, rt_c, res_c;
  logic [3:0]  cnt_c;
  logic        hlt_a, hlt_b, hlt_c;
  wb_state_t   st_a, st_b, st_c;

  gcd_writeback_stage dut_a (
    .clk(clk), .rst(rst), .MW_valid(mw_valid), .MW_RD(mw_rd), .MW_ALUout(mw_aluout),
    .halt_req(halt_req), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_a),
    .rt_data(rt_a), .retire_count(cnt_a), .halted(hlt_a), .result(res_a), .state_dbg(st_a)
  );

  gcd_writeback_stage #(.DRAIN_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .MW_valid(mw_valid), .MW_RD(mw_rd), .MW_ALUout(mw_aluout),
    .halt_req(halt_req), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_b),
    .rt_data(rt_b), .retire_count(cnt_b), .halted(hlt_b), .result(res_b), .state_dbg(st_b)
  );

  gcd_writeback_stage #(.COUNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .MW_valid(mw_valid), .MW_RD(mw_rd), .MW_ALUout(mw_aluout),
    .halt_req(halt_req), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_c),
    .rt_data(rt_c), .retire_count(cnt_c), .halted(hlt_c), .result(res_c), .state_dbg(st_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b0; mw_valid = 1'b0; mw_rd = '0; mw_aluout = '0;
    halt_req = 1'b0; rs_addr = '0; rt_addr = '0;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] cnt;
    logic        halted;
    logic [31:0] result;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  logic [31:0] m_regs   [3][32];
  logic [31:0] m_cnt    [3];
  logic [31:0] m_result [3];
  bit          m_halted [3];
  bit          m_pend   [3];
  int          m_when   [3];
  int          drain_of [3] = '{2, 0, 2};
  logic [31:0] cmax     [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15};

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 32; r++) m_regs[k][r] = '0;
      m_cnt[k] = '0; m_result[k] = '0; m_halted[k] = 0; m_pend[k] = 0; m_when[k] = 0;
    end
  end

  // Drives one cycle of inputs, records what each instance must show during
  // it, then advances the model across the following clock edge.
  task automatic cycle(input bit r, input bit v, input logic [4:0] rd, input logic [31:0] d,
                       input bit h, input logic [4:0] a, input logic [4:0] b);
    exp_t e;
    bit   wr, go;
    @(posedge clk);
    #1;
    rst = r; mw_valid = v; mw_rd = rd; mw_aluout = d; halt_req = h; rs_addr = a; rt_addr = b;
    for (int k = 0; k < 3; k++) begin
      wr       = v && (rd != 0) && !m_halted[k];
      e.inst   = 2'(k);
      e.rs     = (a == 0) ? 32'd0 : (wr && a == rd) ? d : m_regs[k][a];
      e.rt     = (b == 0) ? 32'd0 : (wr && b == rd) ? d : m_regs[k][b];
      e.cnt    = m_cnt[k];
      e.halted = m_halted[k];
      e.result = m_result[k];
      exp_q.push_back(e);
      if (!r) begin
        for (int i = 0; i < 32; i++) m_regs[k][i] = '0;
        m_cnt[k] = '0; m_result[k] = '0; m_halted[k] = 0; m_pend[k] = 0;
      end else begin
        go = 0;
        if (!m_halted[k]) begin
          if (!m_pend[k] && h) begin
            m_pend[k] = 1;
            m_when[k] = cyc + drain_of[k];
          end
          if (m_pend[k] && cyc == m_when[k]) go = 1;
        end
        if (v && !m_halted[k] && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        if (go) begin
          m_result[k] = (wr && rd == 5'd2) ? d : m_regs[k][2];
          m_halted[k] = 1;
          m_pend[k]   = 0;
        end
        if (wr) m_regs[k][rd] = d;
      end
    end
    cyc++;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle%0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.inst)
          2'd0: begin
            chk("rs_data", 0, rs_a, e.rs); chk("rt_data", 0, rt_a, e.rt);
            chk("retire_count", 0, cnt_a, e.cnt); chk("halted", 0, {31'd0, hlt_a}, {31'd0, e.halted});
            chk("result", 0, res_a, e.result);
          end
          2'd1: begin
            chk("rs_data", 1, rs_b, e.rs); chk("rt_data", 1, rt_b, e.rt);
            chk("retire_count", 1, cnt_b, e.cnt); chk("halted", 1, {31'd0, hlt_b}, {31'd0, e.halted});
            chk("result", 1, res_b, e.result);
          end
          default: begin
            chk("rs_data", 2, rs_c, e.rs); chk("rt_data", 2, rt_c, e.rt);
            chk("retire_count", 2, {28'd0, cnt_c}, e.cnt); chk("halted", 2, {31'd0, hlt_c}, {31'd0, e.halted});
            chk("result", 2, res_c, e.result);
          end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset with a live write presented
    cycle(0, 1, 5'd3, 32'hAAAA, 0, 5'd4, 5'd0);
    cycle(0, 1, 5'd3, 32'hBBBB, 0, 5'd4, 5'd3);
    cycle(1, 0, 5'd0, 32'h0, 0, 5'd3, 5'd3);
    // write with same-cycle bypass, then storage
    cycle(1, 1, 5'd5, 32'h1234, 0, 5'd5, 5'd5);
    cycle(1, 0, 5'd0, 32'h0, 0, 5'd5, 5'd0);
    // r0 write is a retirement but no register update
    cycle(1, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0);
    cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 5'd5);
    // halt drain with a result write in flight
    cycle(1, 1, 5'd2, 32'd6, 0, 5'd2, 5'd0);
    cycle(1, 0, 5'd0, 32'd0, 1, 5'd2, 5'd0);
    cycle(1, 1, 5'd2, 32'h15, 0, 5'd2, 5'd2);
    cycle(1, 0, 5'd0, 32'd0, 1, 5'd2, 5'd0);
    cycle(1, 1, 5'd2, 32'h77, 0, 5'd2, 5'd0);
    cycle(1, 1, 5'd3, 32'h88, 1, 5'd3, 5'd2);
    cycle(1, 0, 5'd0, 32'd0, 0, 5'd3, 5'd2);
    // reset while halted
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd2, 5'd5);
    cycle(1, 0, 5'd0, 32'd0, 0, 5'd2, 5'd5);
    // halt together with a write of the result register
    cycle(1, 1, 5'd2, 32'd9, 1, 5'd2, 5'd2);
    cycle(1, 1, 5'd2, 32'd10, 0, 5'd2, 5'd0);
    // reset mid-drain for the two-cycle instances
    cycle(0, 1, 5'd4, 32'd1, 0, 5'd2, 5'd4);
    cycle(1, 0, 5'd0, 32'd0, 0, 5'd2, 5'd4);
    // counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++)
      cycle(1, 1, 5'($urandom_range(0, 7)), $urandom, 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    cycle(1, 0, 5'd0, 32'd0, 0, 5'd1, 5'd2);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 24) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
